// File: rtl/mem_bridge_pkg.sv
// Shared constants and types for the memory-stage bridge: region map,
// timer register offsets, timer FSM states and CTRL field layout.
package bridge_pkg;

  // Region map (byte addresses)
  localparam logic [31:0] DM_LIMIT   = 32'h0000_2FFF;
  localparam logic [31:0] TIMER_BASE = 32'h0000_7F00;
  localparam logic [31:0] IG_BASE    = 32'h0000_7F20;

  // Timer register byte offsets from TIMER_BASE
  localparam logic [3:0] CTRL_OFS   = 4'd0;
  localparam logic [3:0] PRESET_OFS = 4'd4;
  localparam logic [3:0] COUNT_OFS  = 4'd8;

  // Timer MODE encodings; 2'b1x falls back to one-shot behaviour
  localparam logic [1:0] ONESHOT  = 2'b00;
  localparam logic [1:0] AUTOLOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timer_state_e;

  // CTRL[3:0] = {IM, MODE[1:0], EN}
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } timer_ctrl_t;

endpackage

// File: rtl/mem_bridge_if.sv
// M-stage side and data-memory side signals of the bridge, bundled so the
// pipeline (master) and the bridge (slave) see mirrored directions.
interface mem_bridge_if;

  // M-stage request
  logic [31:0] M_Addr;
  logic [3:0]  M_Byteen;
  logic [31:0] M_WData;
  logic        M_Load;
  logic        Req;
  logic        Interrupt;

  // Returned to the pipeline / CP0
  logic [31:0] M_RData;
  logic        BusErr;
  logic [5:0]  HWInt;

  // Data memory port
  logic [31:0] DM_Addr;
  logic [3:0]  DM_Byteen;
  logic [31:0] DM_WData;
  logic [31:0] DM_RData;

  modport slave (
    input  M_Addr, M_Byteen, M_WData, M_Load, Req, Interrupt, DM_RData,
    output M_RData, BusErr, HWInt, DM_Addr, DM_Byteen, DM_WData
  );

  modport master (
    output M_Addr, M_Byteen, M_WData, M_Load, Req, Interrupt, DM_RData,
    input  M_RData, BusErr, HWInt, DM_Addr, DM_Byteen, DM_WData
  );

endinterface

// File: rtl/mem_bridge_timer_core.sv
// Countdown timer: CTRL/PRESET/COUNT registers, irq flag and the
// IDLE->LOAD->CNT->INT sequencer. Bus writes arrive already validated.
module timer_core
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we,
  input  logic [3:0]  i_ofs,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  timer_state_e r_state, w_state_nxt;
  timer_ctrl_t  r_ctrl,  w_ctrl_nxt;
  logic [31:0]  r_preset, w_preset_nxt;
  logic [31:0]  r_count,  w_count_nxt;
  logic         r_irq_flag, w_irq_nxt;

  // Register all timer state; every register clears on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values;
      // blocking would let later lines see already-updated state.
      r_state    <= w_state_nxt;
      r_ctrl     <= w_ctrl_nxt;
      r_preset   <= w_preset_nxt;
      r_count    <= w_count_nxt;
      r_irq_flag <= w_irq_nxt;
    end
  end

  // Next state and register updates: FSM first, bus write overrides last.
  always_comb begin
    // NOTE: every output gets a hold value first so no path leaves a
    // variable unassigned (which would infer a latch).
    w_state_nxt  = r_state;
    w_ctrl_nxt   = r_ctrl;
    w_preset_nxt = r_preset;
    w_count_nxt  = r_count;
    w_irq_nxt    = r_irq_flag;

    unique case (r_state)
      IDLE: begin
        if (r_ctrl.en) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_count_nxt = r_preset;
        w_irq_nxt   = 1'b0;
        w_state_nxt = CNT;
      end
      CNT: begin
        if (!r_ctrl.en) begin
          w_state_nxt = IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // PRESET of 0 lands here directly, so it expires like PRESET=1
          w_count_nxt = '0;
          w_irq_nxt   = 1'b1;
          w_state_nxt = INT;
        end
      end
      INT: begin
        if (r_ctrl.mode == AUTOLOAD) begin
          // flag is visible only for the INT cycle in auto-reload
          w_irq_nxt   = 1'b0;
          w_state_nxt = LOAD;
        end else begin
          // one-shot (and reserved 1x modes): disarm, keep the flag
          w_ctrl_nxt.en = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A CTRL write wins over the FSM's own EN clear and clears the flag.
    // PRESET writes only take effect at the next LOAD.
    if (i_we) begin
      if (i_ofs == CTRL_OFS) begin
        w_ctrl_nxt = timer_ctrl_t'(i_wdata[3:0]);
        w_irq_nxt  = 1'b0;
      end else if (i_ofs == PRESET_OFS) begin
        w_preset_nxt = i_wdata;
      end
    end
  end

  // Register read mux; CTRL is zero-extended.
  always_comb begin
    o_rdata = '0;
    unique case (i_ofs)
      CTRL_OFS:   o_rdata = {28'd0, r_ctrl};
      PRESET_OFS: o_rdata = r_preset;
      COUNT_OFS:  o_rdata = r_count;
      default:    o_rdata = '0;
    endcase
  end

  assign o_irq = r_irq_flag & r_ctrl.im;

endmodule

// File: rtl/mem_bridge.sv
// Memory-stage bridge: decodes the M-stage address into data memory, the
// countdown timer and the interrupt generator, returns the load word and
// raises bus errors and hardware interrupt lines.
module mem_bridge
  import bridge_pkg::*;
(
  input logic         clk,
  input logic         reset,
  mem_bridge_if.slave bus
);

  logic        w_in_dm;
  logic        w_in_tm;
  logic        w_in_ig;
  logic        w_store;
  logic        w_access;
  logic        w_bus_err;
  logic        w_strobe;
  logic        w_int_rise;
  logic        w_timer_irq;
  logic [31:0] w_tm_rdata;
  logic [3:0]  w_tm_ofs;

  logic        r_int_q;
  logic        r_ig_pending;

  // Region decode; the fourth word of the timer block is unmapped.
  assign w_in_dm  = (bus.M_Addr <= DM_LIMIT);
  assign w_in_tm  = (bus.M_Addr[31:4] == TIMER_BASE[31:4]) &&
                    (bus.M_Addr[3:2] != 2'b11);
  assign w_in_ig  = (bus.M_Addr[31:2] == IG_BASE[31:2]);
  assign w_store  = |bus.M_Byteen;
  assign w_access = bus.M_Load | w_store;
  assign w_tm_ofs = {bus.M_Addr[3:2], 2'b00};

  // Unmapped access, store to read-only COUNT, or partial-word store to a
  // bridge register all fault and must not change any state.
  assign w_bus_err = (w_access & ~(w_in_dm | w_in_tm | w_in_ig)) |
                     (w_store & w_in_tm & (w_tm_ofs == COUNT_OFS)) |
                     (w_store & (w_in_tm | w_in_ig) & (bus.M_Byteen != 4'hF));

  assign w_strobe = w_store & ~bus.Req & ~w_bus_err;

  // Data memory sees the request unchanged except for region-gated enables.
  assign bus.DM_Addr   = bus.M_Addr;
  assign bus.DM_WData  = bus.M_WData;
  assign bus.DM_Byteen = w_in_dm ? bus.M_Byteen : 4'h0;

  timer_core u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_strobe & w_in_tm),
    .i_ofs   (w_tm_ofs),
    .i_wdata (bus.M_WData),
    .o_rdata (w_tm_rdata),
    .o_irq   (w_timer_irq)
  );

  assign w_int_rise = bus.Interrupt & ~r_int_q;

  // Interrupt generator: latch a rising edge; a valid store acknowledges,
  // but a coincident new edge keeps it pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_int_q      <= 1'b0;
      r_ig_pending <= 1'b0;
    end else begin
      r_int_q <= bus.Interrupt;
      if (w_int_rise) begin
        r_ig_pending <= 1'b1;
      end else if (w_strobe & w_in_ig) begin
        r_ig_pending <= 1'b0;
      end
    end
  end

  // Load-data mux by region; unmapped addresses read as zero.
  always_comb begin
    bus.M_RData = '0;
    if (w_in_dm) begin
      bus.M_RData = bus.DM_RData;
    end else if (w_in_tm) begin
      bus.M_RData = w_tm_rdata;
    end else if (w_in_ig) begin
      bus.M_RData = {31'd0, r_ig_pending};
    end
  end

  assign bus.BusErr = w_bus_err;
  assign bus.HWInt  = {4'd0, r_ig_pending, w_timer_irq};

endmodule
